// File: rtl/prog_sequencer_pkg.sv
// rtl/prog_sequencer_pkg.sv - shared types and constants for the boot/run sequencer
package seq_pack;

  localparam int INSTR_W = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    START = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  typedef enum logic [2:0] {
    STAT_NONE     = 3'd0,
    STAT_OK       = 3'd1,
    STAT_TIMEOUT  = 3'd2,
    STAT_OVERFLOW = 3'd3,
    STAT_EMPTY    = 3'd4,
    STAT_ABORT    = 3'd5
  } seq_status_t;

endpackage

// File: rtl/prog_sequencer_if.sv
// rtl/prog_sequencer_if.sv - program image loader stream with source/sink modports
interface prog_sequencer_if;
  import seq_pack::*;

  logic               ld_valid;
  logic               ld_ready;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);

endinterface

// File: rtl/prog_sequencer_sat_counter.sv
// rtl/prog_sequencer_sat_counter.sv - clearable counter that saturates at LIMIT
module sat_counter #(
  parameter int          WIDTH = 16,
  parameter int unsigned LIMIT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o
);

  localparam logic [WIDTH-1:0] LIM    = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIM)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // High when this cycle's increment lands exactly on LIMIT.
  assign at_limit_o = en_i && !clear_i && (count_q == LIM_M1);

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - loads a program image into IMEM, then runs and times the CPU
module prog_sequencer
  import seq_pack::*;
#(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          AW         = 10,
  parameter int          CW         = 16,
  parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               reload,
  input  logic               abort,
  prog_sequencer_if.slave    ld,
  output logic               imem_we,
  output logic [AW-1:0]      imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               cpu_start,
  input  logic               cpu_done,
  output logic               busy,
  output logic [2:0]         status,
  output logic [AW:0]        prog_len,
  output logic [CW-1:0]      cycle_count
);

  seq_state_t  state_q, state_d;
  seq_status_t status_q, status_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   len_q, len_d;

  logic hs;
  logic ptr_full;
  logic go_ok;
  logic run_at_limit;

  assign hs       = ld.ld_valid && (state_q == LOAD);
  assign ptr_full = (wptr_q == AW'(IMEM_DEPTH - 1));
  assign go_ok    = go && ((state_q == IDLE) || (state_q == DONE));

  sat_counter #(
    .WIDTH (CW),
    .LIMIT (MAX_CYCLES)
  ) u_cycle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (state_q == ARM),
    .en_i       (state_q == RUN),
    .count_o    (cycle_count),
    .at_limit_o (run_at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= STAT_NONE;
      wptr_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      wptr_q   <= wptr_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          status_d = STAT_NONE;
          if (reload) begin
            state_d = LOAD;
          end else if (len_q != '0) begin
            state_d = ARM;
          end else begin
            state_d  = DONE;
            status_d = STAT_EMPTY;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d  = DONE;
          status_d = STAT_ABORT;
        end else if (hs && ld.ld_last) begin
          state_d = ARM;
        end else if (hs && ptr_full) begin
          state_d  = DONE;
          status_d = STAT_OVERFLOW;
        end
      end
      ARM:   state_d = START;
      START: state_d = RUN;
      RUN: begin
        // A done that coincides with the limit still counts as a clean finish.
        if (cpu_done) begin
          state_d  = DONE;
          status_d = STAT_OK;
        end else if (abort) begin
          state_d  = DONE;
          status_d = STAT_ABORT;
        end else if (run_at_limit) begin
          state_d  = DONE;
          status_d = STAT_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer wraps to 0 on the overflowing write; prog_len carries the extra bit.
  always_comb begin
    wptr_d = wptr_q;
    len_d  = len_q;
    if (go_ok && reload) begin
      wptr_d = '0;
      len_d  = '0;
    end else if (hs) begin
      wptr_d = wptr_q + 1'b1;
      len_d  = len_q + 1'b1;
    end
  end

  always_comb begin
    ld.ld_ready = (state_q == LOAD);
    imem_we     = hs;
    imem_waddr  = wptr_q;
    imem_wdata  = ld.ld_data;
    cpu_start   = (state_q == START);
    cpu_reset   = !((state_q == START) || (state_q == RUN));
    busy        = (state_q == LOAD) || (state_q == ARM) ||
                  (state_q == START) || (state_q == RUN);
    status      = status_q;
    prog_len    = len_q;
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - self-checking bench for prog_sequencer
module tb_prog_sequencer;

  localparam int MAXC  = 20;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int CW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, go, reload, abort, cpu_done;
  logic          imem_we, cpu_reset, cpu_start, busy;
  logic [AW-1:0] imem_waddr;
  logic [8:0]    imem_wdata;
  logic [2:0]    status;
  logic [AW:0]   prog_len;
  logic [CW-1:0] cycle_count;

  prog_sequencer_if ld_if ();

  prog_sequencer #(
    .IMEM_DEPTH (DEPTH),
    .AW         (AW),
    .CW         (CW),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .reload      (reload),
    .abort       (abort),
    .ld          (ld_if),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .cpu_reset   (cpu_reset),
    .cpu_start   (cpu_start),
    .cpu_done    (cpu_done),
    .busy        (busy),
    .status      (status),
    .prog_len    (prog_len),
    .cycle_count (cycle_count)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] act_addr[$];
  logic [8:0]    act_data[$];
  int            n_starts = 0;
  int            n_low    = 0;

  always @(posedge clk) begin
    if (imem_we) begin
      act_addr.push_back(imem_waddr);
      act_data.push_back(imem_wdata);
    end
    if (cpu_start) n_starts++;
    if (!cpu_reset) n_low++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go_cmd(input logic rl);
    go     = 1'b1;
    reload = rl;
    tick();
    go     = 1'b0;
    reload = 1'b0;
  endtask

  task automatic stream(input logic [8:0] words[$], input bit last, input bit gaps);
    for (int i = 0; i < words.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          ld_if.ld_valid = 1'b0;
          tick();
        end
      end
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = words[i];
      ld_if.ld_last  = last && (i == words.size() - 1);
      #1;
      chk("ld_ready", 32'(ld_if.ld_ready), 32'd1);
      chk("imem_we", 32'(imem_we), 32'd1);
      tick();
    end
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
  endtask

  task automatic check_writes(input logic [8:0] words[$], input int base);
    chk("wr_count", 32'(act_addr.size() - base), 32'(words.size()));
    for (int i = 0; i < words.size(); i++) begin
      if (base + i < act_addr.size()) begin
        chk("wr_addr", 32'(act_addr[base+i]), 32'(i));
        chk("wr_data", 32'(act_data[base+i]), 32'(words[i]));
      end
    end
  endtask

  // Reference: done on RUN cycle k (1..MAXC) finishes OK with count k,
  // anything later or never times out at MAXC.
  task automatic run_check(input int done_at, input int exp_len, input bit stale);
    int w = 0;
    int k = 0;
    int r;
    int low0;
    int st0;
    logic [2:0] exp_st;
    low0 = n_low;
    st0  = n_starts;
    if (done_at >= 1 && done_at <= MAXC) begin
      r = done_at;
      exp_st = 3'd1;
    end else begin
      r = MAXC;
      exp_st = 3'd2;
    end
    while (!cpu_start && w < 8) begin
      tick();
      w++;
    end
    chk("start_latency", 32'(w), 32'd1);
    chk("cpu_reset_in_start", 32'(cpu_reset), 32'd0);
    chk("count_cleared", 32'(cycle_count), 32'd0);
    cpu_done = stale;
    while (k < MAXC + 5) begin
      tick();
      k++;
      if (!busy) break;
      cpu_done = (k == done_at);
    end
    cpu_done = 1'b0;
    chk("run_cycles", 32'(k - 1), 32'(r));
    chk("busy_after_run", 32'(busy), 32'd0);
    chk("status", 32'(status), 32'(exp_st));
    chk("cycle_count", 32'(cycle_count), 32'(r));
    chk("prog_len", 32'(prog_len), 32'(exp_len));
    chk("cpu_reset_low_cycles", 32'(n_low - low0), 32'(r + 1));
    chk("start_pulses", 32'(n_starts - st0), 32'd1);
    chk("cpu_reset_in_done", 32'(cpu_reset), 32'd1);
  endtask

  initial begin
    logic [8:0] words[$];
    int base;
    int st0;
    int len;

    rst_n = 1'b0; go = 1'b0; reload = 1'b0; abort = 1'b0; cpu_done = 1'b0;
    ld_if.ld_valid = 1'b0; ld_if.ld_data = '0; ld_if.ld_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_cpu_start", 32'(cpu_start), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_ld_ready", 32'(ld_if.ld_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_cycle_count", 32'(cycle_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Rerun with nothing resident
    st0 = n_starts;
    go_cmd(1'b0);
    chk("empty_status", 32'(status), 32'd4);
    chk("empty_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("empty_no_start", 32'(n_starts - st0), 32'd0);
    chk("empty_status_hold", 32'(status), 32'd4);

    // Directed three-word image
    words = '{9'h1AE, 9'h131, 9'h03F};
    base = act_addr.size();
    go_cmd(1'b1);
    chk("load_status_cleared", 32'(status), 32'd0);
    stream(words, 1'b1, 1'b0);
    check_writes(words, base);
    run_check(5, 3, 1'b0);

    // Rerun of the resident image
    base = act_addr.size();
    go_cmd(1'b0);
    chk("rerun_no_ld_ready", 32'(ld_if.ld_ready), 32'd0);
    run_check(5, 3, 1'b0);
    chk("rerun_no_writes", 32'(act_addr.size() - base), 32'd0);

    go_cmd(1'b0);
    run_check(0, 3, 1'b1);
    go_cmd(1'b0);
    run_check(MAXC, 3, 1'b0);

    // Randomized images and run lengths
    for (int it = 0; it < 6; it++) begin
      words.delete();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) words.push_back(9'($urandom));
      base = act_addr.size();
      go_cmd(1'b1);
      stream(words, 1'b1, 1'b1);
      check_writes(words, base);
      run_check($urandom_range(1, MAXC + 4), len, 1'($urandom_range(0, 1)));
    end

    // Full image without last overflows
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(9'($urandom));
    st0  = n_starts;
    base = act_addr.size();
    go_cmd(1'b1);
    stream(words, 1'b0, 1'b0);
    chk("ovf_status", 32'(status), 32'd3);
    chk("ovf_prog_len", 32'(prog_len), 32'(DEPTH));
    chk("ovf_ld_ready", 32'(ld_if.ld_ready), 32'd0);
    chk("ovf_busy", 32'(busy), 32'd0);
    check_writes(words, base);
    repeat (3) tick();
    chk("ovf_no_start", 32'(n_starts - st0), 32'd0);

    // Full image with last on the final address is legal
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(9'($urandom));
    base = act_addr.size();
    go_cmd(1'b1);
    stream(words, 1'b1, 1'b0);
    check_writes(words, base);
    run_check(3, DEPTH, 1'b0);

    // Abort mid-load after two words
    words = '{9'h055, 9'h1C3};
    go_cmd(1'b1);
    stream(words, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_status", 32'(status), 32'd5);
    chk("abort_prog_len", 32'(prog_len), 32'd2);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);

    // Asynchronous reset in the middle of a run
    go_cmd(1'b0);
    tick();
    tick();
    tick();
    chk("midrun_busy", 32'(busy), 32'd1);
    chk("midrun_cpu_reset", 32'(cpu_reset), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_status", 32'(status), 32'd0);
    chk("arst_prog_len", 32'(prog_len), 32'd0);
    chk("arst_cycle_count", 32'(cycle_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
